// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
//
// Watches the output of an upstream binary counter and confirms that it moves
// exactly as its count enable says it should. The value seen in the previous
// cycle, together with the enable presented in that cycle, predicts the value
// expected now:
//   - enable was high: expect the previous value plus one, wrapping modulo
//     2^WIDTH.
//   - enable was low:  expect the previous value unchanged.
//
// A small FSM controls when comparisons are made:
//   IDLE  (00) - monitoring off.
//   ARM   (01) - one cycle that loads the reference value. No comparison.
//   RUN   (10) - compares every cycle. A mismatch leads to FAULT.
//   FAULT (11) - err is held high until ack_err, then returns to ARM to
//                resynchronise.
// Dropping check_en returns the FSM to IDLE from any state.
// Only a fault that is entered from RUN increments err_count.
// A legal all-ones -> 0 rollover seen in RUN produces a one-cycle wrap_pulse.
//
// Optional feature:
//   COUNT_CHECKER_WRAP_COUNT_EN - when this macro is defined, a modulo-2^WRAP_W
//   counter of wrap pulses drives wrap_count. When it is undefined, that
//   register is not built and wrap_count is tied to zero.
//
// Parameters:
//   WIDTH  - width of the monitored count value
//   ERR_W  - width of the saturating error counter
//   WRAP_W - width of the wrap counter
//
// Ports:
//   clock      in   rising-edge clock for all state
//   clear      in   synchronous active-low reset
//   c_enable   in   count enable presented to the upstream counter
//   q_in       in   upstream counter value [WIDTH]
//   check_en   in   1 = monitor, 0 = go to IDLE
//   ack_err    in   acknowledges a latched fault (used only in FAULT)
//   state      out  FSM state [2]
//   err        out  high while in FAULT
//   err_count  out  saturating number of faults detected [ERR_W]
//   wrap_pulse out  one-cycle pulse per legal wrap
//   wrap_count out  number of wraps, modulo 2^WRAP_W [WRAP_W]
//   last_q     out  q_in registered from the previous cycle [WIDTH]
// ---------------------------------------------------------------------------
module count_checker #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              c_enable,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              check_en,
  input  logic              ack_err,
  output logic [1:0]        state,
  output logic              err,
  output logic [ERR_W-1:0]  err_count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_q
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARM   = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] last_q_reg;
  logic             prev_en_reg;
  logic [ERR_W-1:0] err_count_reg;
  logic             wrap_pulse_reg;

  logic [WIDTH-1:0] expected_q;
  logic             mismatch;
  logic             running;
  logic             fault_entry;
  logic             legal_wrap;
  logic             err_full;

  // ---------------------------------------------------------------------
  // Prediction and the events derived from it
  // ---------------------------------------------------------------------

  // The upstream counter either advanced by one or held its value. The
  // natural overflow of the WIDTH-bit add is the modulo wrap we want.
  assign expected_q = prev_en_reg ? (last_q_reg + WIDTH'(1)) : last_q_reg;
  assign mismatch   = (q_in != expected_q);

  // Comparisons happen only in RUN. When check_en is low in the same cycle,
  // the sample is discarded: there is no FAULT entry and no wrap pulse.
  assign running     = (state_reg == ST_RUN) && check_en;
  assign fault_entry = running && mismatch;

  // A legal wrap needs the enable to have been high. All-ones -> 0 with the
  // enable low is caught as an ordinary mismatch instead.
  assign legal_wrap  = running && prev_en_reg && (&last_q_reg) && (q_in == '0);

  assign err_full    = &err_count_reg;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (!check_en) begin
      // Leaving monitoring takes priority over an acknowledge or a mismatch
      // in the same cycle.
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_ARM;
        ST_ARM:   state_next = ST_RUN;
        ST_RUN:   state_next = mismatch ? ST_FAULT : ST_RUN;
        ST_FAULT: state_next = ack_err ? ST_ARM : ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg      <= ST_IDLE;
      last_q_reg     <= '0;
      prev_en_reg    <= 1'b0;
      err_count_reg  <= '0;
      wrap_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_q_reg     <= q_in;
      prev_en_reg    <= c_enable;
      wrap_pulse_reg <= legal_wrap;
      if (fault_entry && !err_full) begin
        err_count_reg <= err_count_reg + ERR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional wrap counter
  // ---------------------------------------------------------------------
`ifdef COUNT_CHECKER_WRAP_COUNT_EN
  logic [WRAP_W-1:0] wrap_count_reg;

  // This counter advances on the same edge that raises wrap_pulse, so both
  // outputs change together.
  always_ff @(posedge clock) begin
    if (!clear) begin
      wrap_count_reg <= '0;
    end else if (legal_wrap) begin
      wrap_count_reg <= wrap_count_reg + WRAP_W'(1);
    end
  end

  assign wrap_count = wrap_count_reg;
`else
  assign wrap_count = '0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign state      = state_reg;
  assign err        = (state_reg == ST_FAULT);
  assign err_count  = err_count_reg;
  assign wrap_pulse = wrap_pulse_reg;
  assign last_q     = last_q_reg;

endmodule

// File: tb/tb_count_checker.sv
// ---------------------------------------------------------------------------
// tb_count_checker
//
// Testbench for count_checker.
//
// Inputs are driven 1 ns after each rising edge. At each edge a behavioural
// model of the checker is updated from the inputs that the edge sampled.
// Every DUT output is then compared against the model 1 ns later.
//
// A second instance with ERR_W=2 shares all of its inputs with the main
// instance, so that err_count saturation can be observed.
//
// The run consists of directed scenarios followed by a randomized phase. It
// ends with one summary line.
// ---------------------------------------------------------------------------
module tb_count_checker;

  logic       clock;
  logic       clear;
  logic       c_enable;
  logic [3:0] q_in;
  logic       check_en;
  logic       ack_err;

  logic [1:0] state,      state2;
  logic       err,        err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic       wrap_pulse, wrap_pulse2;
  logic [7:0] wrap_count, wrap_count2;
  logic [3:0] last_q,     last_q2;

  count_checker #(.WIDTH(4), .ERR_W(8), .WRAP_W(8)) dut (
    .clock      (clock),
    .clear      (clear),
    .c_enable   (c_enable),
    .q_in       (q_in),
    .check_en   (check_en),
    .ack_err    (ack_err),
    .state      (state),
    .err        (err),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .last_q     (last_q)
  );

  count_checker #(.WIDTH(4), .ERR_W(2), .WRAP_W(8)) dut2 (
    .clock      (clock),
    .clear      (clear),
    .c_enable   (c_enable),
    .q_in       (q_in),
    .check_en   (check_en),
    .ack_err    (ack_err),
    .state      (state2),
    .err        (err2),
    .err_count  (err_count2),
    .wrap_pulse (wrap_pulse2),
    .wrap_count (wrap_count2),
    .last_q     (last_q2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference model.
  // Model state encoding: 0 = idle, 1 = arm, 2 = run, 3 = fault.
  int m_state;
  int m_last_q;
  int m_prev_en;
  int m_faults;
  int m_pulse;
  int m_wraps;

  int cnt;     // value a correct upstream counter would present next
  int npulse;  // wrap pulses seen on the main instance

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int expect_q;
    bit mis;
    bit run_ok;
    if (!clear) begin
      m_state   = 0;
      m_last_q  = 0;
      m_prev_en = 0;
      m_faults  = 0;
      m_pulse   = 0;
      m_wraps   = 0;
    end else begin
      expect_q = m_prev_en ? (m_last_q + 1) % 16 : m_last_q;
      mis      = (int'(q_in) != expect_q);
      run_ok   = (m_state == 2) && check_en;
      m_pulse  = (run_ok && m_prev_en == 1 && m_last_q == 15 && q_in == 0) ? 1 : 0;
`ifdef COUNT_CHECKER_WRAP_COUNT_EN
      if (m_pulse == 1) m_wraps = (m_wraps + 1) % 256;
`endif
      if (run_ok && mis) m_faults++;
      if (!check_en)          m_state = 0;
      else if (m_state == 0)  m_state = 1;
      else if (m_state == 1)  m_state = 2;
      else if (m_state == 2)  m_state = mis ? 3 : 2;
      else                    m_state = ack_err ? 1 : 3;
      m_last_q  = int'(q_in);
      m_prev_en = int'(c_enable);
    end
  endtask

  task automatic check_all();
    check("state",        32'(state),      32'(m_state));
    check("err",          32'(err),        32'(m_state == 3));
    check("err_count",    32'(err_count),  32'((m_faults > 255) ? 255 : m_faults));
    check("err_count_w2", 32'(err_count2), 32'((m_faults > 3) ? 3 : m_faults));
    check("wrap_pulse",   32'(wrap_pulse), 32'(m_pulse));
    check("wrap_count",   32'(wrap_count), 32'(m_wraps));
    check("last_q",       32'(last_q),     32'(m_last_q));
  endtask

  // Drives one cycle. qf < 0 presents the correct counter value, otherwise
  // qf is forced onto q_in. After the edge, cnt follows what a real counter
  // would do from the value that was actually presented.
  task automatic cyc(input logic clr, input logic ck, input logic ce,
                     input logic ack, input int qf);
    int qv;
    qv       = (qf < 0) ? cnt : qf;
    clear    = clr;
    check_en = ck;
    c_enable = ce;
    ack_err  = ack;
    q_in     = qv[3:0];
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    if (wrap_pulse === 1'b1) npulse++;
    cnt = (qv + int'(ce)) % 16;
  endtask

  initial begin
    cnt    = 0;
    npulse = 0;
    m_state = 0; m_last_q = 0; m_prev_en = 0;
    m_faults = 0; m_pulse = 0; m_wraps = 0;
    clear = 1'b0; check_en = 1'b0; c_enable = 1'b0; ack_err = 1'b0; q_in = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("rst_state", 32'(state), 0);
    check("rst_err_count", 32'(err_count), 0);

    // Correct counter from 0 for 40 cycles: IDLE -> ARM -> RUN, two wraps.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    check("arm_state", 32'(state), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    check("run_state", 32'(state), 2);
    for (int i = 0; i < 38; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    check("count40_wraps", 32'(npulse), 2);
    check("count40_err", 32'(err), 0);

    // Jump 5 -> 7 with the enable high, then acknowledge.
    while (cnt != 5) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 7);
    check("jump_state", 32'(state), 3);
    check("jump_err", 32'(err), 1);
    check("jump_err_count", 32'(err_count), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, -1);
    check("ack_state", 32'(state), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    check("rerun_state", 32'(state), 2);
    check("rerun_err", 32'(err), 0);

    // Hold at 9 with the enable low, then change to 10 with the enable
    // still low.
    while (cnt != 9) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, -1);
    check("hold_state", 32'(state), 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 10);
    check("hold_fault_state", 32'(state), 3);
    check("hold_fault_count", 32'(err_count), 2);

    // ack_err and check_en=0 in the same cycle in FAULT: go to IDLE.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, -1);
    check("ackoff_state", 32'(state), 0);
    check("ackoff_err_count", 32'(err_count), 2);

    // Five more fault/ack cycles: the 2-bit counter saturates.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, (cnt + 2) % 16);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, -1);
    end
    check("sat_err_count_w2", 32'(err_count2), 3);
    check("sat_err_count", 32'(err_count), 7);

    // Reset in RUN with q_in=15 and the enable high.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    while (cnt != 15) cyc(1'b1, 1'b1, 1'b1, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, -1);
    check("midrst_state", 32'(state), 0);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_last_q", 32'(last_q), 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("midrst_no_wrap", 32'(wrap_pulse), 0);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(39) != 0), ($urandom_range(19) != 0), 1'($urandom_range(1)),
          ($urandom_range(5) == 0), ($urandom_range(9) == 0) ? int'($urandom_range(15)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
